host_bus_arbiter: RTL

- Shares the CPU's address bus and main bus between the running CPU and an external host port (front panel / debug loader) that reads and writes memory bytes.
- On a host request it lets the CPU finish to an instruction-step boundary, freezes the CPU clock, and disables the control-word drivers (ctrlen).
- It then drives the buses itself for the access and restores CPU ownership afterwards.
- Sits beside the CPU top level and feeds its ctrlen and clock-enable.

---
 rtl/host_bus_pkg.sv | 30 +++
 rtl/cycle_counter.sv | 30 +++
 rtl/host_bus_arbiter.sv | 190 +++++++++++++++++++
 3 files changed

// File: rtl/host_bus_pkg.sv
// Shared constants for the host bus arbiter: FSM state codes, counter width
// and the legal ranges of the timing parameters.
package host_bus_pkg;

  localparam int CNT_W = 8;

  localparam logic [2:0] ST_IDLE     = 3'd0;
  localparam logic [2:0] ST_DRAIN    = 3'd1;
  localparam logic [2:0] ST_TURN_ON  = 3'd2;
  localparam logic [2:0] ST_ACCESS   = 3'd3;
  localparam logic [2:0] ST_ACK      = 3'd4;
  localparam logic [2:0] ST_GAP      = 3'd5;
  localparam logic [2:0] ST_TURN_OFF = 3'd6;
  localparam logic [2:0] ST_ERR      = 3'd7;

  localparam int SETTLE_MIN  = 1;
  localparam int SETTLE_MAX  = 15;
  localparam int ACCESS_MIN  = 1;
  localparam int ACCESS_MAX  = 15;
  localparam int TIMEOUT_MIN = 1;
  localparam int TIMEOUT_MAX = 255;

  // Out-of-range parameters are pulled to the nearest legal value.
  function automatic logic [CNT_W-1:0] clamp_cycles(input int val, input int lo, input int hi);
    int c;
    c = (val < lo) ? lo : ((val > hi) ? hi : val);
    return c[CNT_W-1:0];
  endfunction

endpackage

// File: rtl/cycle_counter.sv
// Loadable down-counter shared by the settle, access and drain-timeout phases.
// done is high while the count is zero, i.e. during the last cycle of a phase.
module cycle_counter
  import host_bus_pkg::*;
(
  input  logic             clk,
  input  logic             rstn,
  input  logic             load,
  input  logic             en,
  input  logic [CNT_W-1:0] load_val,
  output logic             done
);

  logic [CNT_W-1:0] count_q;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of block evaluation order.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      count_q <= '0;
    end else if (load) begin
      count_q <= load_val;
    end else if (en && (count_q != '0)) begin
      count_q <= count_q - 1'b1;
    end
  end

  assign done = (count_q == '0);

endmodule

// File: rtl/host_bus_arbiter.sv
// Hands the CPU address/main bus to an external host port: waits for a step
// boundary, freezes the CPU, performs the byte access, then gives the bus back.
module host_bus_arbiter
  import host_bus_pkg::*;
#(
  parameter int SETTLE_CYCLES = 1,
  parameter int ACCESS_CYCLES = 2,
  parameter int DRAIN_TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        host_req,
  input  logic        host_we,
  input  logic [15:0] host_addr,
  input  logic [7:0]  host_wdata,
  output logic        host_ack,
  output logic        host_err,
  output logic [7:0]  host_rdata,
  input  logic        step_boundary,
  input  logic        cpu_hlt,
  output logic        cpu_clk_en,
  output logic        ctrlen,
  output logic        abus_oe,
  output logic [15:0] abus_out,
  output logic        dbus_oe,
  output logic [7:0]  dbus_out,
  input  logic [7:0]  dbus_in,
  output logic        mem_rd,
  output logic        mem_wr,
  output logic        busy
);

  // Counter preload is (phase length - 1) because done marks the final cycle.
  localparam logic [CNT_W-1:0] SETTLE_LOAD =
    clamp_cycles(SETTLE_CYCLES, SETTLE_MIN, SETTLE_MAX) - 1'b1;
  localparam logic [CNT_W-1:0] ACCESS_LOAD =
    clamp_cycles(ACCESS_CYCLES, ACCESS_MIN, ACCESS_MAX) - 1'b1;
  localparam logic [CNT_W-1:0] DRAIN_LOAD = (DRAIN_TIMEOUT == 0) ? '0 :
    clamp_cycles(DRAIN_TIMEOUT, TIMEOUT_MIN, TIMEOUT_MAX) - 1'b1;
  localparam logic DRAIN_TIMEOUT_EN = (DRAIN_TIMEOUT != 0);

  logic [2:0]       state_q, state_d;
  logic             we_q, we_d;
  logic [15:0]      addr_q, addr_d;
  logic [7:0]       wdata_q, wdata_d;
  logic             cnt_load;
  logic [CNT_W-1:0] cnt_val;
  logic             cnt_done;
  logic             acc_d;
  logic             cpu_owns_d;
  logic             rd_capture;

  logic        host_ack_q, host_err_q, cpu_clk_en_q, ctrlen_q, busy_q;
  logic        abus_oe_q, dbus_oe_q, mem_rd_q, mem_wr_q;
  logic [15:0] abus_out_q;
  logic [7:0]  dbus_out_q, host_rdata_q;

  cycle_counter u_cycle_counter (
    .clk      (clk),
    .rstn     (rstn),
    .load     (cnt_load),
    .en       (!cnt_load),
    .load_val (cnt_val),
    .done     (cnt_done)
  );

  // NOTE: every always_comb output gets a default first so no path can leave
  // it unassigned and infer a latch.
  always_comb begin
    state_d  = state_q;
    we_d     = we_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    cnt_load = 1'b0;
    cnt_val  = '0;
    case (state_q)
      ST_IDLE: begin
        if (host_req) begin
          we_d     = host_we;
          addr_d   = host_addr;
          wdata_d  = host_wdata;
          cnt_load = 1'b1;
          if (cpu_hlt || step_boundary) begin
            state_d = ST_TURN_ON;
            cnt_val = SETTLE_LOAD;
          end else begin
            state_d = ST_DRAIN;
            cnt_val = DRAIN_LOAD;
          end
        end
      end
      ST_DRAIN: begin
        // A boundary on the timeout cycle still wins over the error.
        if (step_boundary || cpu_hlt) begin
          state_d  = ST_TURN_ON;
          cnt_load = 1'b1;
          cnt_val  = SETTLE_LOAD;
        end else if (DRAIN_TIMEOUT_EN && cnt_done) begin
          state_d = ST_ERR;
        end
      end
      ST_TURN_ON: begin
        if (cnt_done) begin
          state_d  = ST_ACCESS;
          cnt_load = 1'b1;
          cnt_val  = ACCESS_LOAD;
        end
      end
      ST_ACCESS: begin
        if (cnt_done) state_d = ST_ACK;
      end
      ST_ACK: state_d = ST_GAP;
      ST_GAP: begin
        cnt_load = 1'b1;
        if (host_req) begin
          we_d    = host_we;
          addr_d  = host_addr;
          wdata_d = host_wdata;
          state_d = ST_ACCESS;
          cnt_val = ACCESS_LOAD;
        end else begin
          state_d = ST_TURN_OFF;
          cnt_val = SETTLE_LOAD;
        end
      end
      ST_TURN_OFF: begin
        if (cnt_done) state_d = ST_IDLE;
      end
      ST_ERR:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  assign acc_d      = (state_d == ST_ACCESS);
  assign cpu_owns_d = (state_d == ST_IDLE) || (state_d == ST_DRAIN) || (state_d == ST_ERR);
  assign rd_capture = (state_q == ST_ACCESS) && cnt_done && !we_q;

  // Outputs are decoded from the next state so they line up with state_q.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q      <= ST_IDLE;
      we_q         <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      cpu_clk_en_q <= 1'b1;
      ctrlen_q     <= 1'b1;
      abus_oe_q    <= 1'b0;
      abus_out_q   <= '0;
      dbus_oe_q    <= 1'b0;
      dbus_out_q   <= '0;
      mem_rd_q     <= 1'b0;
      mem_wr_q     <= 1'b0;
      host_ack_q   <= 1'b0;
      host_err_q   <= 1'b0;
      busy_q       <= 1'b0;
      host_rdata_q <= '0;
    end else begin
      state_q      <= state_d;
      we_q         <= we_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      cpu_clk_en_q <= cpu_owns_d;
      ctrlen_q     <= cpu_owns_d;
      abus_oe_q    <= acc_d;
      abus_out_q   <= acc_d ? addr_d : '0;
      dbus_oe_q    <= acc_d && we_d;
      dbus_out_q   <= (acc_d && we_d) ? wdata_d : '0;
      mem_rd_q     <= acc_d && !we_d;
      mem_wr_q     <= acc_d && we_d;
      host_ack_q   <= (state_d == ST_ACK) || (state_d == ST_ERR);
      host_err_q   <= (state_d == ST_ERR);
      busy_q       <= (state_d != ST_IDLE);
      if (rd_capture) host_rdata_q <= dbus_in;
    end
  end

  assign host_ack   = host_ack_q;
  assign host_err   = host_err_q;
  assign host_rdata = host_rdata_q;
  assign cpu_clk_en = cpu_clk_en_q;
  assign ctrlen     = ctrlen_q;
  assign abus_oe    = abus_oe_q;
  assign abus_out   = abus_out_q;
  assign dbus_oe    = dbus_oe_q;
  assign dbus_out   = dbus_out_q;
  assign mem_rd     = mem_rd_q;
  assign mem_wr     = mem_wr_q;
  assign busy       = busy_q;

endmodule
